// File: rtl/clk_div_cfg_ctrl_pkg.sv
// Shared types and constants for the clock-divider configuration controller.
// State encoding, requester indices and the minimum settle time live here.
package clk_div_cfg_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_GATE   = 3'd2,
        ST_LOAD   = 3'd3,
        ST_SETTLE = 3'd4,
        ST_ACK    = 3'd5
    } state_t;

    localparam int REQ_A      = 0;
    localparam int REQ_B      = 1;
    localparam int MIN_SETTLE = 2;

endpackage

// File: rtl/clk_div_cfg_ctrl_rr_arb2.sv
// Two-input round-robin arbiter: combinational one-hot grant, registered pointer.
// The pointer only moves when both inputs contend, so a lone requester never steals the next turn.
module rr_arb2
    import clk_div_cfg_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    logic favour_b;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = favour_b ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            favour_b <= 1'b0;
        end else if (update && (req == 2'b11)) begin
            favour_b <= grant[REQ_A];
        end
    end

endmodule

// File: rtl/clk_div_cfg_ctrl.sv
// Owns the divider enable/ratio; arbitrates two requesters and sequences each ratio
// change as gate -> drain -> load -> settle -> acknowledge.
//
// state  | meaning
// BOOT   | first cycle after reset, enables the divider at DEFAULT_RATIO
// IDLE   | arbitrate pending requests, choose fast or normal path
// GATE   | enable low, drain old clock for DRAIN_CYC cycles
// LOAD   | new ratio present, re-enable divider, arm settle counter
// SETTLE | wait for the new clock to settle
// ACK    | one-cycle ack pulse to the granted requester
module clk_div_cfg_ctrl
    import clk_div_cfg_ctrl_pkg::*;
#(
    parameter int               WIDTH         = 8,
    parameter logic [WIDTH-1:0] DEFAULT_RATIO = 8'd32,
    parameter int               DRAIN_CYC     = 2
) (
    input  logic             i_ref_clk,
    input  logic             i_rst_n,
    input  logic [1:0]       i_req,
    input  logic [WIDTH-1:0] i_ratio_a,
    input  logic [WIDTH-1:0] i_ratio_b,
    output logic [1:0]       o_ack,
    output logic             o_clk_en,
    output logic [WIDTH-1:0] o_div_ratio,
    output logic             o_busy
);

    state_t           state_q, state_d;
    logic             clk_en_q, clk_en_d;
    logic [WIDTH-1:0] ratio_q, ratio_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [1:0]       ack_q, ack_d;
    logic             busy_q, busy_d;
    logic             gnt_b_q, gnt_b_d;
    logic [3:0]       drain_q, drain_d;
    logic [WIDTH:0]   settle_q, settle_d;

    logic [1:0]       grant;
    logic             arb_update;
    logic [WIDTH-1:0] gnt_ratio;
    logic [WIDTH:0]   settle_len;

    assign arb_update = (state_q == ST_IDLE) && (i_req != 2'b00);
    assign gnt_ratio  = grant[REQ_B] ? i_ratio_b : i_ratio_a;

    // Ratios 0 and 1 bypass the divider but still get a minimum settle window.
    assign settle_len = (cap_q <= WIDTH'(1)) ? (WIDTH+1)'(MIN_SETTLE) : {cap_q, 1'b0};

    rr_arb2 u_arb (
        .clk    (i_ref_clk),
        .rst_n  (i_rst_n),
        .req    (i_req),
        .update (arb_update),
        .grant  (grant)
    );

    always_comb begin
        state_d  = state_q;
        clk_en_d = clk_en_q;
        ratio_d  = ratio_q;
        cap_d    = cap_q;
        ack_d    = 2'b00;
        gnt_b_d  = gnt_b_q;
        drain_d  = drain_q;
        settle_d = settle_q;

        case (state_q)
            ST_BOOT: begin
                clk_en_d = 1'b1;
                state_d  = ST_IDLE;
            end
            ST_IDLE: begin
                if (i_req != 2'b00) begin
                    cap_d   = gnt_ratio;
                    gnt_b_d = grant[REQ_B];
                    if ((gnt_ratio == ratio_q) && clk_en_q) begin
                        ack_d   = grant;
                        state_d = ST_ACK;
                    end else begin
                        clk_en_d = 1'b0;
                        drain_d  = 4'(DRAIN_CYC - 1);
                        state_d  = ST_GATE;
                    end
                end
            end
            ST_GATE: begin
                if (drain_q == 4'd0) begin
                    ratio_d = cap_q;
                    state_d = ST_LOAD;
                end else begin
                    drain_d = drain_q - 4'd1;
                end
            end
            ST_LOAD: begin
                clk_en_d = 1'b1;
                settle_d = settle_len - (WIDTH+1)'(1);
                state_d  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_q == '0) begin
                    ack_d[gnt_b_q] = 1'b1;
                    state_d        = ST_ACK;
                end else begin
                    settle_d = settle_q - (WIDTH+1)'(1);
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_BOOT;
            clk_en_q <= 1'b0;
            ratio_q  <= DEFAULT_RATIO;
            cap_q    <= DEFAULT_RATIO;
            ack_q    <= 2'b00;
            busy_q   <= 1'b1;
            gnt_b_q  <= 1'b0;
            drain_q  <= 4'd0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            clk_en_q <= clk_en_d;
            ratio_q  <= ratio_d;
            cap_q    <= cap_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
            gnt_b_q  <= gnt_b_d;
            drain_q  <= drain_d;
            settle_q <= settle_d;
        end
    end

    assign o_ack       = ack_q;
    assign o_clk_en    = clk_en_q;
    assign o_div_ratio = ratio_q;
    assign o_busy      = busy_q;

endmodule
